rl_action_selector: RTL

Parametrised action-selection stage for the RL policy datapath. It sits after MLP inference. It accepts a Q-value vector and an externally computed legality mask, then scans the vector over several cycles, `LANES` entries per cycle. It returns a masked greedy action, an epsilon-greedy action or a uniformly seeded random legal action, with a start/done handshake. It replaces the fixed 10-action combinational mask/argmax with a configurable-width, multi-mode, pipelined selector.

---
 rtl/rl_action_selector_if.sv | 31 +++
 rtl/rl_action_selector.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rl_action_selector_if.sv
// rtl/rl_action_selector_if.sv - request/result bundle for the RL action selector
interface rl_action_selector_if #(
  parameter int N_ACT = 10,
  parameter int Q_W   = 16
);
  localparam int ACT_W = $clog2(N_ACT);

  logic                      start;
  logic [N_ACT-1:0][Q_W-1:0] q_vec;
  logic [N_ACT-1:0]          legal_mask;
  logic [1:0]                mode;
  logic [7:0]                epsilon;
  logic                      seed_load;
  logic [15:0]               seed;
  logic                      busy;
  logic                      done;
  logic [ACT_W-1:0]          action;
  logic [Q_W-1:0]            action_q;
  logic                      explored;
  logic                      no_legal;

  modport master (
    output start, q_vec, legal_mask, mode, epsilon, seed_load, seed,
    input  busy, done, action, action_q, explored, no_legal
  );

  modport slave (
    input  start, q_vec, legal_mask, mode, epsilon, seed_load, seed,
    output busy, done, action, action_q, explored, no_legal
  );
endinterface

// File: rtl/rl_action_selector.sv
// rtl/rl_action_selector.sv - multi-cycle masked greedy / epsilon-greedy / random-legal selector
module rl_action_selector #(
  parameter int          N_ACT     = 10,
  parameter int          Q_W       = 16,
  parameter int          LANES     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic            clk,
  input logic            rst_n,
  rl_action_selector_if.slave bus
);
  localparam int ACT_W = $clog2(N_ACT);
  localparam int GRPS  = (N_ACT + LANES - 1) / LANES;
  localparam int GRP_W = (GRPS > 1) ? $clog2(GRPS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;
  state_t state, state_nx;

  logic [N_ACT-1:0][Q_W-1:0] q_r;
  logic [N_ACT-1:0]          mask_r;
  logic [1:0]                mode_r;
  logic [7:0]                eps_r, re_r;
  logic [ACT_W-1:0]          s_r, s_raw, s_draw;
  logic [GRP_W-1:0]          grp;
  logic [15:0]               lfsr, lfsr_adv;

  logic [ACT_W-1:0]      best_idx, ge_idx, first_idx;
  logic signed [Q_W-1:0] best_q;
  logic                  any_legal, ge_found;

  logic [ACT_W-1:0]      nb_idx, n_ge_idx, n_first_idx;
  logic signed [Q_W-1:0] nb_q;
  logic                  n_any, n_ge_found;
  int                    idx;

  logic [ACT_W-1:0] action_r, res_action;
  logic [Q_W-1:0]   action_q_r, res_q;
  logic             explored_r, no_legal_r, explore, accept, last_grp;

  assign accept   = (state == IDLE) && bus.start;
  assign last_grp = (grp == GRP_W'(GRPS - 1));
  assign lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign s_raw    = lfsr[ACT_W-1:0];
  assign s_draw   = (int'(s_raw) >= N_ACT) ? ACT_W'(int'(s_raw) - N_ACT) : s_raw;
  assign explore  = (mode_r == 2'd2) || ((mode_r == 2'd1) && (re_r < eps_r));

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DECIDE);
  assign bus.action   = action_r;
  assign bus.action_q = action_q_r;
  assign bus.explored = explored_r;
  assign bus.no_legal = no_legal_r;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SCAN;
      SCAN:    if (last_grp) state_nx = DECIDE;
      DECIDE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One lane group per cycle; running trackers chain across lanes so lower indices win ties.
  always_comb begin
    nb_idx      = best_idx;
    nb_q        = best_q;
    n_any       = any_legal;
    n_ge_found  = ge_found;
    n_ge_idx    = ge_idx;
    n_first_idx = first_idx;
    idx         = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(grp) * LANES + l;
      if (idx < N_ACT && mask_r[idx]) begin
        if (!n_any || $signed(q_r[idx]) > nb_q) begin
          nb_idx = ACT_W'(idx);
          nb_q   = $signed(q_r[idx]);
        end
        if (!n_any) n_first_idx = ACT_W'(idx);
        if (!n_ge_found && idx >= int'(s_r)) begin
          n_ge_found = 1'b1;
          n_ge_idx   = ACT_W'(idx);
        end
        n_any = 1'b1;
      end
    end
  end

  always_comb begin
    res_action = '0;
    if (n_any) res_action = explore ? (n_ge_found ? n_ge_idx : n_first_idx) : nb_idx;
    res_q = q_r[res_action];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      q_r        <= '0;
      mask_r     <= '0;
      mode_r     <= '0;
      eps_r      <= '0;
      re_r       <= '0;
      s_r        <= '0;
      grp        <= '0;
      best_idx   <= '0;
      best_q     <= '0;
      any_legal  <= 1'b0;
      ge_found   <= 1'b0;
      ge_idx     <= '0;
      first_idx  <= '0;
      action_r   <= '0;
      action_q_r <= '0;
      explored_r <= 1'b0;
      no_legal_r <= 1'b0;
    end else begin
      state <= state_nx;
      // A seed load wins over the accept advance; the accept still draws the old value.
      if (bus.seed_load)  lfsr <= (bus.seed == 16'h0) ? LFSR_SEED : bus.seed;
      else if (accept)    lfsr <= lfsr_adv;
      if (accept) begin
        q_r       <= bus.q_vec;
        mask_r    <= bus.legal_mask;
        mode_r    <= bus.mode;
        eps_r     <= bus.epsilon;
        re_r      <= lfsr[15:8];
        s_r       <= s_draw;
        grp       <= '0;
        best_idx  <= '0;
        best_q    <= '0;
        any_legal <= 1'b0;
        ge_found  <= 1'b0;
        ge_idx    <= '0;
        first_idx <= '0;
      end else if (state == SCAN) begin
        grp       <= grp + 1'b1;
        best_idx  <= nb_idx;
        best_q    <= nb_q;
        any_legal <= n_any;
        ge_found  <= n_ge_found;
        ge_idx    <= n_ge_idx;
        first_idx <= n_first_idx;
        if (last_grp) begin
          action_r   <= res_action;
          action_q_r <= res_q;
          explored_r <= n_any && explore;
          no_legal_r <= !n_any;
        end
      end
    end
  end
endmodule
